lfsr_seq_ctrl: RTL and testbench



---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_seed_shifter.sv | 59 +++++
 rtl/lfsr_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer slice.
//   LFSR_W_DEF  : default LFSR length (number of seed bits)
//   CNT_W_DEF   : default width of the run-length and ones counters
//   seq_state_e : sequencer FSM states, 2-bit encoding
package lfsr_pkg;

  localparam int unsigned LFSR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StFin  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/lfsr_seed_shifter.sv
// Parallel-load, MSB-first seed shift register with bit counter.
// Ports:
//   clk, arst_n : clock, asynchronous active-low reset
//   load        : capture seed, arm bit counter to WIDTH-1
//   shift       : shift left by one (zero fill), count down
//   clear       : drop any remaining bits (abort)
//   seed        : parallel seed value
//   msb         : current serial bit (flop output)
//   last        : high while the final bit is being presented
module lfsr_seed_shifter
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] seed,
  output logic             msb,
  output logic             last
);

  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (load) begin
      sr_d      = seed;
      bit_cnt_d = BitW'(WIDTH - 1);
    end else if (shift) begin
      // Zero fill means the serial output falls to 0 once all bits are out.
      sr_d = sr_q << 1;
      if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - BitW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign msb  = sr_q[WIDTH-1];
  assign last = (bit_cnt_q == '0);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for a serial-load LFSR: shifts a seed in (en=0), runs the LFSR
// in feedback mode (en=1) for run_len cycles, then pulses done for one cycle.
// Optional ones counter on lfsr_q during RUN enabled by LFSR_SEQ_ONES_CNT_EN;
// when undefined ones_cnt is tied to 0.
// Ports:
//   clk, arst_n      : clock, asynchronous active-low reset
//   start, abort     : request pulse (IDLE only), synchronous cancel
//   seed, run_len    : captured on accepted start
//   lfsr_en, lfsr_si : drive the LFSR (0 = serial load, 1 = feedback)
//   lfsr_q           : LFSR serial output
//   busy, done       : high in LOAD/RUN, one-cycle completion pulse
//   ones_cnt         : saturating count of ones seen on lfsr_q during RUN
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LFSR_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] run_len,
  output logic             lfsr_en,
  output logic             lfsr_si,
  input  logic             lfsr_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             busy_q, lfsr_en_q, done_q;
  logic             accept;
  logic             seed_last;

  assign accept = (state_q == StIdle) && start;

  lfsr_seed_shifter #(
    .WIDTH (WIDTH)
  ) u_seed_shifter (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (accept),
    .shift  ((state_q == StLoad) && !abort),
    .clear  ((state_q == StLoad) && abort),
    .seed   (seed),
    .msb    (lfsr_si),
    .last   (seed_last)
  );

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          run_cnt_d = run_len;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d   = StIdle;
          run_cnt_d = '0;
        end else if (seed_last) begin
          state_d = (run_cnt_q == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (run_cnt_q != '0) run_cnt_d = run_cnt_q - CNT_W'(1);
        if (abort) begin
          state_d   = StIdle;
          run_cnt_d = '0;
        end else if (run_cnt_q == CNT_W'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      run_cnt_q <= '0;
      busy_q    <= 1'b0;
      lfsr_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      busy_q    <= (state_d == StLoad) || (state_d == StRun);
      lfsr_en_q <= (state_d == StRun);
      done_q    <= (state_d == StFin);
    end
  end

  assign busy    = busy_q;
  assign lfsr_en = lfsr_en_q;
  assign done    = done_q;

`ifdef LFSR_SEQ_ONES_CNT_EN
  logic [CNT_W-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (accept) begin
      ones_d = '0;
    end else if ((state_q == StRun) && !abort && lfsr_q && (ones_q != '1)) begin
      ones_d = ones_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ones_q <= '0;
    else         ones_q <= ones_d;
  end

  assign ones_cnt = ones_q;
`else
  logic unused_lfsr_q;
  assign unused_lfsr_q = lfsr_q;
  assign ones_cnt      = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl with a behavioural 4-stage LFSR
// (x^4+x^3+1, q = stage 3) attached. Expected per-cycle outputs and done
// events are queued at stimulus time; a negedge monitor compares them.
module tb_lfsr_seq_ctrl;

  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] seed = '0;
  logic [C-1:0] run_len = '0;
  logic         lfsr_en, lfsr_si, lfsr_q, busy, done;
  logic [C-1:0] ones_cnt;

  lfsr_seq_ctrl #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .abort    (abort),
    .seed     (seed),
    .run_len  (run_len),
    .lfsr_en  (lfsr_en),
    .lfsr_si  (lfsr_si),
    .lfsr_q   (lfsr_q),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  // Environment LFSR, reset by the same arst_n.
  logic [3:0] lfsr_s;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n)      lfsr_s <= 4'b0;
    else if (lfsr_en) lfsr_s <= {lfsr_s[2:0], lfsr_s[3] ^ lfsr_s[2]};
    else              lfsr_s <= {lfsr_s[2:0], lfsr_si};
  end
  assign lfsr_q = lfsr_s[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ones;
  } done_t;

  logic [3:0] exp_tr [int];  // {busy, en, si, done} per absolute cycle
  done_t      done_q [$];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Ones seen on q over len feedback cycles starting from state == seed.
  function automatic int ref_ones(input int sd, input int len);
    int s, n;
    s = sd & 15;
    n = 0;
    for (int i = 0; i < len; i++) begin
      n += (s >> 3) & 1;
      s = ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
    end
    return (n > 255) ? 255 : n;
  endfunction

  always @(negedge clk) begin : monitor
    logic [3:0] e;
    done_t      d;
    if (arst_n && mon_en) begin
      e = exp_tr.exists(cyc) ? exp_tr[cyc] : 4'b0000;
      check("busy/en/si/done", {busy, lfsr_en, lfsr_si, done}, e);
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("ones_cnt", ones_cnt, d.ones);
        end
      end
    end
  end

  // abort_k: relative cycle (1..W+len) in which abort is driven, 0 = none.
  // noise: extra start pulses with junk seed/run_len in LOAD and FIN.
  task automatic run_txn(input logic [W-1:0] sd, input logic [C-1:0] len,
                         input int abort_k, input bit noise);
    int c, fin, last, ones;
    c    = cyc;
    fin  = W + int'(len) + 1;
    last = (abort_k > 0) ? abort_k : fin;
    for (int k = 1; k <= last; k++) begin
      if (k <= W)            exp_tr[c + k] = {1'b1, 1'b0, sd[W - k], 1'b0};
      else if (k < fin)      exp_tr[c + k] = 4'b1100;
      else                   exp_tr[c + k] = 4'b0001;
    end
`ifdef LFSR_SEQ_ONES_CNT_EN
    ones = ref_ones(int'(sd), int'(len));
`else
    ones = 0;
`endif
    if (abort_k == 0) done_q.push_back('{cyc: c + fin, ones: ones});
    start   = 1'b1;
    seed    = sd;
    run_len = len;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = 1'b0;
      seed    = W'($urandom);
      run_len = C'($urandom);
      if (noise && (k == 2 || k == fin)) start = 1'b1;
      if (k == abort_k) abort = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, ak, gap;
    // Reset held for 3 cycles; outputs must be zero throughout.
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {busy, lfsr_en, lfsr_si, done, ones_cnt}, 0);
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end

    run_txn(4'b1001, 8'd5, 0, 1'b0);        // basic
    run_txn(4'b1111, 8'd0, 0, 1'b0);        // zero run_len
    run_txn(4'b1010, 8'd8, W + 2, 1'b0);    // abort on 2nd RUN cycle
    run_txn(4'b0110, 8'd3, 0, 1'b0);        // restart one cycle after abort
    run_txn(4'b1100, 8'd4, 0, 1'b1);        // ignored starts in LOAD and FIN
    run_txn(4'b0001, 8'd15, 0, 1'b0);       // ones count signature
    run_txn(4'b0101, 8'd2, 2, 1'b0);        // abort during LOAD

    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(0, 20);
      ak  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + len) : 0;
      run_txn(W'($urandom), C'(len), ak, 1'($urandom));
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pending_done_events", done_q.size(), 0);

    // Asynchronous reset in the middle of a RUN.
    mon_en  = 1'b0;
    start   = 1'b1;
    seed    = 4'b1111;
    run_len = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 arst_n = 1'b0;
    #1 check("async_reset_outputs", {busy, lfsr_en, lfsr_si, done, ones_cnt}, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
